// File: rtl/inst_sequencer.sv
// Instruction fetch/execute sequencer: fetches one- or two-byte instructions,
// pulses execEn for one cycle per instruction, applies taken branches, halts on 8'hFF.
module inst_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] memAddr,
  output logic       memReq,
  input  logic       memAck,
  input  logic [7:0] memData,
  output logic [7:0] inst,
  output logic [7:0] imm,
  output logic       execEn,
  input  logic       jmpEn,
  input  logic [7:0] jmpAddr,
  output logic       halted,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_FETCH     = 2'd0;
  localparam logic [1:0] S_FETCH_IMM = 2'd1;
  localparam logic [1:0] S_EXECUTE   = 2'd2;
  localparam logic [1:0] S_HALT      = 2'd3;

  // Handshake: a fetch completes on any cycle where memReq && memAck; memAck is
  // ignored when memReq is low and memData is only sampled on that completing cycle.
  logic [1:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] inst_q, inst_d;
  logic [7:0] imm_q, imm_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    imm_d   = imm_q;
    case (state_q)
      S_FETCH: begin
        if (memAck) begin
          inst_d = memData;
          pc_d   = pc_q + 8'd1;
          if (memData == 8'hFF)            state_d = S_HALT;
          else if (memData[7:4] == 4'b0111) state_d = S_FETCH_IMM;
          else                             state_d = S_EXECUTE;
        end
      end
      S_FETCH_IMM: begin
        if (memAck) begin
          imm_d   = memData;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (jmpEn) pc_d = jmpAddr;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      imm_q   <= imm_d;
    end
  end

  // Strobes are gated by rst directly so they drop in the very cycle reset is low.
  assign memReq    = rst & ((state_q == S_FETCH) | (state_q == S_FETCH_IMM));
  assign execEn    = rst & (state_q == S_EXECUTE);
  assign halted    = rst & (state_q == S_HALT);
  assign memAddr   = pc_q;
  assign inst      = inst_q;
  assign imm       = imm_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       memAck = 1'b0;
  logic [7:0] memData = 8'h00;
  logic       jmpEn = 1'b0;
  logic [7:0] jmpAddr = 8'h00;
  logic [7:0] memAddr, inst, imm;
  logic       memReq, execEn, halted;
  logic [1:0] dbg_state;

  logic       w_rst = 1'b0;
  logic       w_ack = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] w_addr, w_inst, w_imm;
  logic       w_req, w_exec, w_halted;
  logic [1:0] w_dbg;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_sequencer u_dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memReq(memReq), .memAck(memAck),
    .memData(memData), .inst(inst), .imm(imm), .execEn(execEn), .jmpEn(jmpEn),
    .jmpAddr(jmpAddr), .halted(halted), .dbg_state(dbg_state)
  );

  inst_sequencer #(.RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .rst(w_rst), .memAddr(w_addr), .memReq(w_req), .memAck(w_ack),
    .memData(w_data), .inst(w_inst), .imm(w_imm), .execEn(w_exec), .jmpEn(1'b0),
    .jmpAddr(8'h00), .halted(w_halted), .dbg_state(w_dbg)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction being assembled and where we are in it.
  typedef enum {M_FETCH, M_IMM, M_EXEC, M_HALT} mphase_t;
  mphase_t    m_phase = M_FETCH;
  logic [7:0] m_pc, m_inst, m_imm;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = M_FETCH; m_pc = 8'h00; m_inst = 8'h00; m_imm = 8'h00;
    end else if (m_phase == M_FETCH && memAck) begin
      m_inst = memData;
      m_pc   = 8'((int'(m_pc) + 1) % 256);
      if (memData == 8'hFF)           m_phase = M_HALT;
      else if (memData[7:4] == 4'h7)  m_phase = M_IMM;
      else                            m_phase = M_EXEC;
    end else if (m_phase == M_IMM && memAck) begin
      m_imm   = memData;
      m_pc    = 8'((int'(m_pc) + 1) % 256);
      m_phase = M_EXEC;
    end else if (m_phase == M_EXEC) begin
      if (jmpEn) m_pc = jmpAddr;
      m_phase = M_FETCH;
    end
    exp_q.push_back({m_pc, m_inst, m_imm});
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    logic [23:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("model_memAddr", memAddr, e[23:16]);
      chk("model_inst",    inst,    e[15:8]);
      chk("model_imm",     imm,     e[7:0]);
      chk("model_memReq",  8'(memReq), 8'(rst && (m_phase == M_FETCH || m_phase == M_IMM)));
      chk("model_execEn",  8'(execEn), 8'(rst && m_phase == M_EXEC));
      chk("model_halted",  8'(halted), 8'(rst && m_phase == M_HALT));
    end
  end

  // driver: inputs change just after the rising edge, caller checks at the falling edge
  task automatic cycle(input logic r, input logic a, input logic [7:0] d,
                       input logic je, input logic [7:0] ja);
    @(posedge clk);
    #1;
    rst = r; memAck = a; memData = d; jmpEn = je; jmpAddr = ja;
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int n;
    // reset with ack/FF presented: nothing may move
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    chk("rst_memReq", 8'(memReq), 8'h00);
    chk("rst_execEn", 8'(execEn), 8'h00);
    chk("rst_halted", 8'(halted), 8'h00);
    chk("rst_inst", inst, 8'h00);
    chk("rst_memAddr", memAddr, 8'h00);

    // single-byte instruction, zero wait: two cycles
    cycle(1'b1, 1'b1, 8'h0B, 1'b0, 8'h00);
    chk("first_memReq", 8'(memReq), 8'h01);
    chk("first_memAddr", memAddr, 8'h00);
    cycle(1'b1, 1'b1, 8'h33, 1'b0, 8'h00);
    chk("sb_execEn", 8'(execEn), 8'h01);
    chk("sb_inst", inst, 8'h0B);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("sb_execEn_off", 8'(execEn), 8'h00);
    chk("sb_next_memReq", 8'(memReq), 8'h01);
    chk("sb_next_memAddr", memAddr, 8'h01);

    // two-byte instruction, two wait cycles per byte: seven cycles
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    pulses = 0;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b1, 8'h70, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00); pulses += int'(execEn);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); pulses += int'(execEn);
    chk("imm_execEn_c7", 8'(execEn), 8'h01);
    chk("imm_inst", inst, 8'h70);
    chk("imm_imm", imm, 8'h5A);
    chk("imm_memAddr", memAddr, 8'h02);
    chk("imm_pulses", 8'(pulses), 8'h01);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("imm_next_memReq", 8'(memReq), 8'h01);

    // branch: jmpEn in FETCH ignored, in EXECUTE taken
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h0B, 1'b1, 8'h99);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h40);
    chk("jmp_exec_memAddr", memAddr, 8'h01);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("jmp_memAddr", memAddr, 8'h40);
    chk("jmp_memReq", 8'(memReq), 8'h01);

    // PC wrap on the RESET_PC=FF instance
    @(posedge clk); #1; w_rst = 1'b1; w_ack = 1'b1; w_data = 8'h00;
    @(negedge clk);
    chk("wrap_memAddr_ff", w_addr, 8'hFF);
    chk("wrap_memReq", 8'(w_req), 8'h01);
    @(posedge clk); #1; w_ack = 1'b0;
    @(negedge clk);
    chk("wrap_memAddr_00", w_addr, 8'h00);
    chk("wrap_execEn", 8'(w_exec), 8'h01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_next_memReq", 8'(w_req), 8'h01);
    chk("wrap_next_memAddr", w_addr, 8'h00);

    // halt: absorbing despite ack pulses, left only by reset
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      chk("halt_halted", 8'(halted), 8'h01);
      chk("halt_memReq", 8'(memReq), 8'h00);
      chk("halt_memAddr", memAddr, 8'h01);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("unhalt_memReq", 8'(memReq), 8'h01);
    chk("unhalt_memAddr", memAddr, 8'h00);
    chk("unhalt_halted", 8'(halted), 8'h00);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      n = $urandom_range(0, 99);
      if (n < 12)      d = {4'h7, 4'($urandom)};
      else if (n < 14) d = 8'hFF;
      else             d = 8'($urandom);
      cycle(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 60), d,
            1'($urandom_range(0, 1)), 8'($urandom));
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
